// File: rtl/tim_capture_mc.sv
// Multi-channel input-capture timer.
// Each channel has a synchroniser, an arming FSM, a saturating counter and a
// one-entry hold register. A fixed-priority arbiter merges the channel holds
// into one show-ahead capture FIFO with a valid/ready read port.

module tim_capture_ch #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             tick_i,
  input  logic             drain_i,
  input  logic             ovr_clr_i,
  output logic             hold_vld_o,
  output logic [CNT_W-1:0] hold_cnt_o,
  output logic             hold_edg_o,
  output logic             hold_sat_o,
  output logic             ovr_o
);
  typedef enum logic {UNARMED = 1'b0, ARMED = 1'b1} st_e;

  st_e              state_q, state_d;
  logic             s1_q, s2_q, prev_q;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             hold_edg_q, hold_edg_d;
  logic             hold_sat_q, hold_sat_d;
  logic             ovr_q, ovr_d;
  logic             rise, fall, sat;
  logic             start_edge, end_edge, width_mode, mode_off, force_off;
  logic             cap, clr, ovr_set;

  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;
  assign sat  = &cnt_q;

  // Decode the registered mode into its arming edge and closing edge.
  always_comb begin
    start_edge = 1'b0;
    end_edge   = 1'b0;
    width_mode = 1'b0;
    mode_off   = 1'b0;
    case (mode_q)
      3'b001:  begin start_edge = rise;        end_edge = rise;        end
      3'b010:  begin start_edge = fall;        end_edge = fall;        end
      3'b011:  begin start_edge = rise | fall; end_edge = rise | fall; end
      3'b100:  begin start_edge = rise; end_edge = fall; width_mode = 1'b1; end
      3'b101:  begin start_edge = fall; end_edge = rise; width_mode = 1'b1; end
      default: mode_off = 1'b1;
    endcase
  end

  // A disabled channel, an off mode or a mode change this cycle disarms.
  assign force_off = ~en_i | (mode_i != mode_q) | mode_off;

  // Two-flop synchroniser, edge-history flop and registered mode copy.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      mode_q <= '0;
    end else begin
      s1_q   <= in_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      mode_q <= mode_i;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= UNARMED;
    else          state_q <= state_d;
  end

  // FSM next state: arm on the start edge, width modes disarm on capture.
  always_comb begin
    state_d = state_q;
    if (force_off) begin
      state_d = UNARMED;
    end else begin
      case (state_q)
        UNARMED: if (start_edge) state_d = ARMED;
        ARMED:   if (end_edge && width_mode) state_d = UNARMED;
        default: state_d = UNARMED;
      endcase
    end
  end

  // FSM outputs: capture strobe and counter clear.
  always_comb begin
    cap = ~force_off & (state_q == ARMED) & end_edge;
    clr = force_off | cap | ((state_q == UNARMED) & start_edge);
  end

  // Saturating counter; a clear wins over a coincident tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (tick_i && !sat) cnt_d = cnt_q + CNT_W'(1);
  end

  // Hold register: a drain frees the slot for a same-cycle capture.
  always_comb begin
    hold_vld_d = hold_vld_q & ~drain_i;
    hold_cnt_d = hold_cnt_q;
    hold_edg_d = hold_edg_q;
    hold_sat_d = hold_sat_q;
    ovr_set    = cap & hold_vld_q & ~drain_i;
    if (cap && !ovr_set) begin
      hold_vld_d = 1'b1;
      hold_cnt_d = cnt_q;
      hold_edg_d = s2_q;
      hold_sat_d = sat;
    end
    ovr_d = ovr_set | (ovr_q & ~ovr_clr_i);
  end

  // Counter, hold and sticky overrun registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt_q      <= '0;
      hold_vld_q <= 1'b0;
      hold_cnt_q <= '0;
      hold_edg_q <= 1'b0;
      hold_sat_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hold_vld_q <= hold_vld_d;
      hold_cnt_q <= hold_cnt_d;
      hold_edg_q <= hold_edg_d;
      hold_sat_q <= hold_sat_d;
      ovr_q      <= ovr_d;
    end
  end

  assign hold_vld_o = hold_vld_q;
  assign hold_cnt_o = hold_cnt_q;
  assign hold_edg_o = hold_edg_q;
  assign hold_sat_o = hold_sat_q;
  assign ovr_o      = ovr_q;
endmodule

module tim_capture_mc #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [NUM_CH-1:0]           Input_i,
  input  logic [NUM_CH-1:0]           Enable_i,
  input  logic [3*NUM_CH-1:0]         Mode_i,
  input  logic [31:0]                 Prescaler_i,
  input  logic                        Interrupt_Enable_i,
  input  logic                        Overrun_Clr_i,
  output logic                        Rd_Valid_o,
  input  logic                        Rd_Ready_i,
  output logic [CNT_W-1:0]            Rd_Count_o,
  output logic [CH_W-1:0]             Rd_Ch_o,
  output logic                        Rd_Edge_o,
  output logic                        Rd_Sat_o,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Level_o,
  output logic [NUM_CH-1:0]           Overrun_o,
  output logic                        Irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0]  ch;
    logic             edg;
    logic             sat;
  } ent_t;

  logic [31:0]                   pcnt_q;
  logic                          tick;
  logic [NUM_CH-1:0]             hold_vld, hold_edg, hold_sat, drain;
  logic [NUM_CH-1:0][CNT_W-1:0]  hold_cnt;
  logic [CH_W-1:0]               gnt_idx;
  logic                          gnt_any, push, pop, full;
  ent_t                          push_ent, head;
  ent_t                          mem_q [FIFO_DEPTH];
  logic [AW-1:0]                 wr_q, rd_q;
  logic [LW-1:0]                 level_q;
  logic                          irq_q;

  assign tick = (pcnt_q >= Prescaler_i);

  // Free-running shared prescaler; wraps as soon as it reaches the divider.
  always_ff @(posedge Clk) begin
    if (!Reset_n) pcnt_q <= '0;
    else          pcnt_q <= tick ? '0 : pcnt_q + 32'd1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tim_capture_ch #(.CNT_W(CNT_W)) u_ch (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .in_i       (Input_i[i]),
      .en_i       (Enable_i[i]),
      .mode_i     (Mode_i[3*i +: 3]),
      .tick_i     (tick),
      .drain_i    (drain[i]),
      .ovr_clr_i  (Overrun_Clr_i),
      .hold_vld_o (hold_vld[i]),
      .hold_cnt_o (hold_cnt[i]),
      .hold_edg_o (hold_edg[i]),
      .hold_sat_o (hold_sat[i]),
      .ovr_o      (Overrun_o[i])
    );
  end

  // Fixed priority: the lowest-index full hold wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hold_vld[i]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(i);
      end
    end
  end

  assign full = (level_q == LW'(FIFO_DEPTH));
  assign pop  = Rd_Valid_o & Rd_Ready_i;
  assign push = gnt_any & (~full | pop);

  // One-hot drain back to the granted channel when its entry is accepted.
  always_comb begin
    drain = '0;
    for (int i = 0; i < NUM_CH; i++) drain[i] = push & (gnt_idx == CH_W'(i));
  end

  assign push_ent = '{cnt: hold_cnt[gnt_idx], ch: gnt_idx,
                      edg: hold_edg[gnt_idx], sat: hold_sat[gnt_idx]};

  // FIFO storage; contents are don't-care while the slot is not counted.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_q] <= push_ent;
  end

  // FIFO pointers, occupancy and registered interrupt.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      irq_q <= Interrupt_Enable_i & Rd_Valid_o;
    end
  end

  assign head         = mem_q[rd_q];
  assign Rd_Valid_o   = (level_q != '0);
  assign Rd_Count_o   = Rd_Valid_o ? head.cnt : '0;
  assign Rd_Ch_o      = Rd_Valid_o ? head.ch  : '0;
  assign Rd_Edge_o    = Rd_Valid_o & head.edg;
  assign Rd_Sat_o     = Rd_Valid_o & head.sat;
  assign Fifo_Level_o = level_q;
  assign Irq_o        = irq_q;
endmodule

// File: tb/tb_tim_capture_mc.sv
// Bench for tim_capture_mc: directed scenarios, a transaction-level model of
// captures/FIFO compared every cycle, plus literal expectations per scenario.

module tb_tim_capture_mc;
  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int DEP  = 8;
  localparam longint MAXC = (64'd1 << CW) - 1;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic [NCH-1:0]  inp = '0, en = '0;
  logic [3*NCH-1:0] mode = '0;
  logic [31:0]     presc = '0;
  logic            ie = 1'b1, oclr = 1'b0, rdy = 1'b0;
  logic            Rd_Valid, Rd_Edge, Rd_Sat, Irq;
  logic [CW-1:0]   Rd_Count;
  logic [1:0]      Rd_Ch;
  logic [3:0]      Fifo_Level;
  logic [NCH-1:0]  Overrun;

  tim_capture_mc #(.NUM_CH(NCH), .CNT_W(CW), .FIFO_DEPTH(DEP)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Input_i(inp), .Enable_i(en), .Mode_i(mode),
    .Prescaler_i(presc), .Interrupt_Enable_i(ie), .Overrun_Clr_i(oclr),
    .Rd_Valid_o(Rd_Valid), .Rd_Ready_i(rdy), .Rd_Count_o(Rd_Count),
    .Rd_Ch_o(Rd_Ch), .Rd_Edge_o(Rd_Edge), .Rd_Sat_o(Rd_Sat),
    .Fifo_Level_o(Fifo_Level), .Overrun_o(Overrun), .Irq_o(Irq)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- model ----------------
  typedef struct { longint cnt; int ch; bit edg; bit sat; } ent_t;
  ent_t   mq[$];
  ent_t   m_hold [NCH];
  bit     m_hv [NCH];
  bit     m_armed [NCH];
  longint m_snap [NCH];
  bit [2:0] m_mprev [NCH];
  bit [NCH-1:0] m_ovr, h1, h2, h3;
  bit     m_irq;
  longint phase, ticks;

  // Input seen by the edge detector at edge E is the input sampled at E-2
  // (prev: E-3). Count = ticks strictly between clearing edge and capture.
  always @(posedge Clk) begin
    bit tk, pop, push, s2, pv, r, f, off, se, ee, wm;
    bit [NCH-1:0] cap;
    ent_t cent [NCH];
    int g;
    bit [2:0] m;
    if (!Reset_n) begin
      mq.delete();
      for (int i = 0; i < NCH; i++) begin
        m_hv[i] = 0; m_armed[i] = 0; m_mprev[i] = 0;
      end
      m_ovr = '0; h1 = '0; h2 = '0; h3 = '0; m_irq = 0; phase = 0;
    end else begin
      tk = (phase >= longint'(presc));
      pop = (mq.size() > 0) && rdy;
      g = -1;
      for (int i = NCH - 1; i >= 0; i--) if (m_hv[i]) g = i;
      push = (g >= 0) && (mq.size() < DEP || pop);
      cap = '0;
      for (int i = 0; i < NCH; i++) begin
        m = mode[3*i +: 3];
        s2 = h2[i]; pv = h3[i];
        r = s2 & !pv; f = !s2 & pv;
        wm = (m_mprev[i] == 3'd4 || m_mprev[i] == 3'd5);
        se = (m_mprev[i] == 1 || m_mprev[i] == 4) ? r :
             (m_mprev[i] == 2 || m_mprev[i] == 5) ? f : (r | f);
        ee = (m_mprev[i] == 1 || m_mprev[i] == 5) ? r :
             (m_mprev[i] == 2 || m_mprev[i] == 4) ? f : (r | f);
        off = !en[i] || (m != m_mprev[i]) || m_mprev[i] == 0 || m_mprev[i] > 5;
        if (off) m_armed[i] = 0;
        else if (!m_armed[i]) begin
          if (se) begin m_armed[i] = 1; m_snap[i] = ticks + tk; end
        end else if (ee) begin
          cap[i] = 1;
          cent[i].cnt = (ticks - m_snap[i] > MAXC) ? MAXC : ticks - m_snap[i];
          cent[i].sat = (cent[i].cnt == MAXC);
          cent[i].edg = s2;
          cent[i].ch  = i;
          m_snap[i] = ticks + tk;
          if (wm) m_armed[i] = 0;
        end
        m_mprev[i] = m;
      end
      m_irq = ie && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (push) begin mq.push_back(m_hold[g]); m_hv[g] = 0; end
      for (int i = 0; i < NCH; i++) begin
        bit set;
        set = cap[i] && m_hv[i];
        if (cap[i] && !m_hv[i]) begin m_hv[i] = 1; m_hold[i] = cent[i]; end
        m_ovr[i] = set | (m_ovr[i] & !oclr);
      end
      h3 = h2; h2 = h1; h1 = inp;
      phase = tk ? 0 : phase + 1;
      ticks += tk;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    bit v;
    if (chk_en) begin
      v = (mq.size() > 0);
      chk("rd_valid",   longint'(Rd_Valid),   longint'(v));
      chk("rd_count",   longint'(Rd_Count),   v ? mq[0].cnt : 0);
      chk("rd_ch",      longint'(Rd_Ch),      v ? longint'(mq[0].ch) : 0);
      chk("rd_edge",    longint'(Rd_Edge),    v ? longint'(mq[0].edg) : 0);
      chk("rd_sat",     longint'(Rd_Sat),     v ? longint'(mq[0].sat) : 0);
      chk("fifo_level", longint'(Fifo_Level), longint'(mq.size()));
      chk("overrun",    longint'(Overrun),    longint'(m_ovr));
      chk("irq",        longint'(Irq),        longint'(m_irq));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    inp = '0; en = '0; mode = '0; rdy = 1'b0; oclr = 1'b0; presc = '0;
    Reset_n = 1'b0;
    cyc(1);
    Reset_n = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset_valid", longint'(Rd_Valid), 0);
    chk("reset_level", longint'(Fifo_Level), 0);
    chk("reset_irq", longint'(Irq), 0);

    // Ch0 rising period, Prescaler 0, edges 100 apart
    en[0] = 1; mode[2:0] = 3'b001; cyc(5);
    inp[0] = 1; cyc(50); inp[0] = 0; cyc(50);
    inp[0] = 1; cyc(3);
    chk("t1_no_valid_e3", longint'(Rd_Valid), 0);
    cyc(1);
    chk("t1_valid_e4", longint'(Rd_Valid), 1);
    chk("t1_count", longint'(Rd_Count), 99);
    chk("t1_ch", longint'(Rd_Ch), 0);
    chk("t1_edge", longint'(Rd_Edge), 1);
    chk("t1_sat", longint'(Rd_Sat), 0);
    chk("t1_irq_lag", longint'(Irq), 0);
    cyc(1);
    chk("t1_irq", longint'(Irq), 1);
    cyc(45); inp[0] = 0; cyc(50); inp[0] = 1; cyc(5);
    chk("t1_level2", longint'(Fifo_Level), 2);
    chk("t1_head_still", longint'(Rd_Count), 99);
    rdy = 1; cyc(10);
    chk("t1_drained", longint'(Fifo_Level), 0);

    // Ch1 high width, Prescaler 3, two 40-cycle pulses
    do_reset();
    presc = 3; en[1] = 1; mode[5:3] = 3'b100; cyc(5);
    repeat (2) begin inp[1] = 1; cyc(40); inp[1] = 0; cyc(20); end
    chk("t2_level", longint'(Fifo_Level), 2);
    chk("t2_ch", longint'(Rd_Ch), 1);
    chk("t2_edge", longint'(Rd_Edge), 0);
    chk("t2_cnt_range", longint'(Rd_Count >= 9 && Rd_Count <= 11), 1);

    // Ch0 and ch2 both-edge, simultaneous toggles
    do_reset();
    en = 4'b0101; mode[2:0] = 3'b011; mode[8:6] = 3'b011; cyc(5);
    inp = 4'b0101; cyc(10); inp = 4'b0000; cyc(4);
    chk("t3_level1", longint'(Fifo_Level), 1);
    chk("t3_first_ch", longint'(Rd_Ch), 0);
    cyc(1);
    chk("t3_level2", longint'(Fifo_Level), 2);
    chk("t3_head_cnt", longint'(Rd_Count), 9);
    chk("t3_head_edge", longint'(Rd_Edge), 0);

    // Ch3 both-edge with the FIFO blocked: fill, overrun, clear, drain
    do_reset();
    en[3] = 1; mode[11:9] = 3'b011; cyc(5);
    for (int k = 0; k < 10; k++) begin inp[3] = ~inp[3]; cyc(10); end
    chk("t4_full", longint'(Fifo_Level), 8);
    chk("t4_no_ovr", longint'(Overrun), 0);
    inp[3] = ~inp[3]; cyc(10);
    chk("t4_ovr_set", longint'(Overrun), 8);
    chk("t4_still_full", longint'(Fifo_Level), 8);
    oclr = 1; cyc(1); oclr = 0;
    chk("t4_ovr_clr", longint'(Overrun), 0);
    rdy = 1;
    for (int j = 0; j < 9; j++) begin
      chk("t4_drain_cnt", longint'(Rd_Count), 9);
      chk("t4_drain_edge", longint'(Rd_Edge), longint'(j % 2));
      cyc(1);
    end
    chk("t4_empty", longint'(Fifo_Level), 0);

    // Saturation with 8-bit counter
    do_reset();
    en[0] = 1; mode[2:0] = 3'b001; cyc(5);
    inp[0] = 1; cyc(10); inp[0] = 0; cyc(990); inp[0] = 1; cyc(10);
    chk("t5_cnt_sat", longint'(Rd_Count), 255);
    chk("t5_sat", longint'(Rd_Sat), 1);

    // Mid-run reset with 3 entries queued
    do_reset();
    en[0] = 1; mode[2:0] = 3'b011; cyc(5);
    for (int k = 0; k < 4; k++) begin inp[0] = ~inp[0]; cyc(10); end
    chk("t6_queued", longint'(Fifo_Level), 3);
    Reset_n = 0; cyc(1); Reset_n = 1;
    chk("t6_rst_valid", longint'(Rd_Valid), 0);
    chk("t6_rst_level", longint'(Fifo_Level), 0);
    chk("t6_rst_count", longint'(Rd_Count), 0);
    chk("t6_rst_irq", longint'(Irq), 0);
    chk("t6_rst_ovr", longint'(Overrun), 0);
    mode[2:0] = 3'b001; cyc(5);
    inp[0] = 1; cyc(20);
    chk("t6_arm_only", longint'(Rd_Valid), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
